if_fetch: RTL and testbench

IF_FETCH -- requirements
Module: if_fetch

---
 rtl/if_fetch.sv | 105 ++++++++++
 tb/tb_if_fetch.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/if_fetch.sv
// +------------------------------------------------------------------------+
// | if_fetch: single-entry instruction fetch stage with redirect and drain |
// | Rev 1.0                                                                |
// +------------------------------------------------------------------------+
`default_nettype none

module if_fetch #(
  parameter logic [0:31] RESET_PC = 32'h00000000,
  parameter logic [0:31] NOP_INST = 32'hF0000000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        redirect,
  input  logic [0:31] redirect_pc,
  output logic        imem_req,
  output logic [0:31] imem_addr,
  input  logic        imem_ack,
  input  logic [0:31] imem_rdata,
  output logic [0:31] IF_inst,
  output logic [0:31] IF_pc,
  output logic        IF_valid
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_BUSY  = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;

  logic [0:31] pc_q, pc_d;
  logic [0:31] req_addr_q, req_addr_d;
  logic [0:31] buf_inst_q, buf_inst_d;
  logic [0:31] buf_pc_q, buf_pc_d;
  logic        buf_valid_q, buf_valid_d;
  logic [1:0]  state_q, state_d;

  logic        can_issue;
  logic        fill;
  logic        unused_rpc_lsbs;

  assign unused_rpc_lsbs = ^redirect_pc[30:31];

  assign can_issue = (!buf_valid_q || !stall) && !redirect;
  assign imem_req  = reset && ((state_q != S_IDLE) || can_issue);
  assign imem_addr = (state_q == S_IDLE) ? pc_q : req_addr_q;
  // A response accepted while draining belongs to a fetch already abandoned.
  assign fill      = imem_req && imem_ack && !redirect && (state_q != S_DRAIN);

  always_comb begin
    pc_d        = pc_q;
    req_addr_d  = req_addr_q;
    buf_inst_d  = buf_inst_q;
    buf_pc_d    = buf_pc_q;
    buf_valid_d = buf_valid_q;
    state_d     = state_q;

    if (redirect) begin
      pc_d        = {redirect_pc[0:29], 2'b00};
      buf_valid_d = 1'b0;
      if (state_q != S_IDLE) begin
        state_d = imem_ack ? S_IDLE : S_DRAIN;
      end
    end else if (fill) begin
      buf_inst_d  = imem_rdata;
      buf_pc_d    = imem_addr;
      buf_valid_d = 1'b1;
      pc_d        = imem_addr + 32'd4;
      state_d     = S_IDLE;
    end else begin
      if (buf_valid_q && !stall) begin
        buf_valid_d = 1'b0;
      end
      if ((state_q == S_IDLE) && imem_req) begin
        req_addr_d = pc_q;
        state_d    = S_BUSY;
      end else if ((state_q == S_DRAIN) && imem_ack) begin
        state_d = S_IDLE;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      pc_q        <= RESET_PC;
      req_addr_q  <= '0;
      buf_inst_q  <= '0;
      buf_pc_q    <= '0;
      buf_valid_q <= 1'b0;
      state_q     <= S_IDLE;
    end else begin
      pc_q        <= pc_d;
      req_addr_q  <= req_addr_d;
      buf_inst_q  <= buf_inst_d;
      buf_pc_q    <= buf_pc_d;
      buf_valid_q <= buf_valid_d;
      state_q     <= state_d;
    end
  end

  assign IF_inst  = buf_valid_q ? buf_inst_q : NOP_INST;
  assign IF_pc    = buf_valid_q ? buf_pc_q : '0;
  assign IF_valid = buf_valid_q;

endmodule

`default_nettype wire

// File: tb/tb_if_fetch.sv
// +------------------------------------------------------------------------+
// | tb_if_fetch: directed bench for if_fetch with a transaction-level model |
// | Rev 1.0                                                                |
// +------------------------------------------------------------------------+
`default_nettype none

module tb_if_fetch;

  localparam logic [0:31] NOP = 32'hF0000000;

  logic        clk = 1'b0;
  logic        reset, stall, redirect, imem_ack;
  logic [0:31] redirect_pc, imem_rdata;
  logic        imem_req, IF_valid;
  logic [0:31] imem_addr, IF_inst, IF_pc;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  // Model: fetch pointer, one-entry buffer, and an outstanding-request record
  // with a flag saying its response must be thrown away.
  logic [0:31] m_pc, m_binst, m_bpc, m_paddr;
  logic        m_bv, m_pend, m_drop;

  always #5 clk = ~clk;

  if_fetch dut (
    .clk(clk), .reset(reset), .stall(stall), .redirect(redirect),
    .redirect_pc(redirect_pc), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata), .IF_inst(IF_inst),
    .IF_pc(IF_pc), .IF_valid(IF_valid)
  );

  function automatic logic [0:31] mem(input logic [0:31] a);
    return a ^ 32'hC0DE0000;
  endfunction

  function automatic logic f_req();
    return reset && (m_pend || ((!m_bv || !stall) && !redirect));
  endfunction

  function automatic logic [0:31] f_addr();
    return m_pend ? m_paddr : m_pc;
  endfunction

  task automatic cmp(input string n, input logic [0:31] act, input logic [0:31] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", n, act, exp);
    end
  endtask

  task automatic model_step();
    logic        r;
    logic [0:31] a;
    r = f_req();
    a = f_addr();
    if (!reset) begin
      m_pc = 32'h0; m_bv = 1'b0; m_binst = '0; m_bpc = '0;
      m_pend = 1'b0; m_drop = 1'b0; m_paddr = '0;
    end else if (redirect) begin
      m_pc = {redirect_pc[0:29], 2'b00};
      m_bv = 1'b0;
      if (m_pend) begin
        if (imem_ack) begin m_pend = 1'b0; m_drop = 1'b0; end
        else m_drop = 1'b1;
      end
    end else if (r && imem_ack && !m_drop) begin
      m_binst = imem_rdata; m_bpc = a; m_bv = 1'b1;
      m_pc = a + 32'd4; m_pend = 1'b0;
    end else begin
      if (m_bv && !stall) m_bv = 1'b0;
      if (r && imem_ack) begin m_pend = 1'b0; m_drop = 1'b0; end
      else if (r) begin m_pend = 1'b1; m_paddr = a; end
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      cmp("imem_req", {31'b0, imem_req}, {31'b0, f_req()});
      if (f_req()) cmp("imem_addr", imem_addr, f_addr());
      cmp("IF_valid", {31'b0, IF_valid}, {31'b0, m_bv});
      cmp("IF_inst", IF_inst, m_bv ? m_binst : NOP);
      cmp("IF_pc", IF_pc, m_bv ? m_bpc : 32'h0);
    end
  end

  task automatic setin(input logic rs, input logic st, input logic rd,
                       input logic [0:31] rpc, input logic ak);
    reset = rs; stall = st; redirect = rd; redirect_pc = rpc; imem_ack = ak;
    #1;
    imem_rdata = mem(imem_addr);
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic lit(input string n, input logic [0:31] act, input logic [0:31] exp);
    cmp({"lit_", n}, act, exp);
  endtask

  initial begin
    setin(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
    tick();
    chk_en = 1'b1;
    setin(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
    lit("rst_req", {31'b0, imem_req}, 32'h0);
    tick();
    lit("rst_valid", {31'b0, IF_valid}, 32'h0);
    lit("rst_inst", IF_inst, NOP);
    lit("rst_pc", IF_pc, 32'h0);

    // Zero-wait streaming from RESET_PC
    setin(1'b1, 1'b0, 1'b0, 32'h0, 1'b1);
    lit("first_req", {31'b0, imem_req}, 32'h1);
    lit("first_addr", imem_addr, 32'h0);
    tick();
    lit("stream_pc0", IF_pc, 32'h0);
    lit("stream_inst0", IF_inst, 32'hC0DE0000);
    for (int i = 1; i < 4; i++) begin
      setin(1'b1, 1'b0, 1'b0, 32'h0, 1'b1);
      tick();
      lit("stream_pc", IF_pc, 32'(i * 4));
      lit("stream_valid", {31'b0, IF_valid}, 32'h1);
    end
    lit("stream_inst3", IF_inst, 32'hC0DE000C);

    // Wait-state memory at 0x100
    setin(1'b1, 1'b0, 1'b1, 32'h100, 1'b0);
    lit("redir_idle_req", {31'b0, imem_req}, 32'h0);
    tick();
    lit("redir_clear", {31'b0, IF_valid}, 32'h0);
    for (int i = 0; i < 3; i++) begin
      setin(1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
      lit("wait_req", {31'b0, imem_req}, 32'h1);
      lit("wait_addr", imem_addr, 32'h100);
      tick();
      lit("wait_valid", {31'b0, IF_valid}, 32'h0);
      lit("wait_inst", IF_inst, NOP);
    end
    setin(1'b1, 1'b0, 1'b0, 32'h0, 1'b1);
    lit("ack_addr", imem_addr, 32'h100);
    tick();
    lit("cap_pc", IF_pc, 32'h100);
    lit("cap_inst", IF_inst, 32'hC0DE0100);

    // Stall hold with buffer at 0x20
    setin(1'b1, 1'b0, 1'b1, 32'h20, 1'b0);
    tick();
    setin(1'b1, 1'b0, 1'b0, 32'h0, 1'b1);
    tick();
    lit("buf20_pc", IF_pc, 32'h20);
    for (int i = 0; i < 4; i++) begin
      setin(1'b1, 1'b1, 1'b0, 32'h0, 1'b1);
      lit("stall_req", {31'b0, imem_req}, 32'h0);
      tick();
      lit("stall_pc", IF_pc, 32'h20);
      lit("stall_valid", {31'b0, IF_valid}, 32'h1);
    end
    setin(1'b1, 1'b0, 1'b0, 32'h0, 1'b1);
    lit("unstall_addr", imem_addr, 32'h24);
    tick();
    lit("unstall_pc", IF_pc, 32'h24);

    // Redirect while 0x40 outstanding, drain, refetch at 0x200
    setin(1'b1, 1'b0, 1'b1, 32'h40, 1'b0);
    tick();
    setin(1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
    lit("issue40_addr", imem_addr, 32'h40);
    tick();
    setin(1'b1, 1'b0, 1'b1, 32'h203, 1'b0);
    lit("busy_redir_addr", imem_addr, 32'h40);
    tick();
    lit("drain_valid0", {31'b0, IF_valid}, 32'h0);
    setin(1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
    lit("drain_req", {31'b0, imem_req}, 32'h1);
    lit("drain_addr", imem_addr, 32'h40);
    tick();
    setin(1'b1, 1'b0, 1'b0, 32'h0, 1'b1);
    tick();
    lit("drain_discard", {31'b0, IF_valid}, 32'h0);
    setin(1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
    lit("target_addr", imem_addr, 32'h200);
    tick();
    setin(1'b1, 1'b0, 1'b0, 32'h0, 1'b1);
    tick();
    lit("target_pc", IF_pc, 32'h200);

    // Redirect with ack and stall together, in IDLE and in BUSY
    setin(1'b1, 1'b1, 1'b1, 32'h300, 1'b1);
    lit("rs_idle_req", {31'b0, imem_req}, 32'h0);
    tick();
    lit("rs_idle_inst", IF_inst, NOP);
    setin(1'b1, 1'b1, 1'b0, 32'h0, 1'b1);
    lit("rs_next_addr", imem_addr, 32'h300);
    tick();
    lit("rs_next_pc", IF_pc, 32'h300);
    setin(1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
    tick();
    setin(1'b1, 1'b1, 1'b1, 32'h400, 1'b1);
    tick();
    lit("rs_busy_drop", {31'b0, IF_valid}, 32'h0);
    setin(1'b1, 1'b0, 1'b0, 32'h0, 1'b1);
    lit("rs_busy_addr", imem_addr, 32'h400);
    tick();
    lit("rs_busy_inst", IF_inst, 32'hC0DE0400);

    // Address wrap, then reset mid-request with a late ack
    setin(1'b1, 1'b0, 1'b1, 32'hFFFFFFFC, 1'b0);
    tick();
    setin(1'b1, 1'b0, 1'b0, 32'h0, 1'b1);
    tick();
    lit("wrap_pc", IF_pc, 32'hFFFFFFFC);
    setin(1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
    lit("wrap_addr", imem_addr, 32'h0);
    tick();
    setin(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
    lit("midrst_req", {31'b0, imem_req}, 32'h0);
    tick();
    lit("midrst_valid", {31'b0, IF_valid}, 32'h0);
    lit("midrst_inst", IF_inst, NOP);
    setin(1'b1, 1'b0, 1'b1, 32'h500, 1'b1);
    lit("late_ack_req", {31'b0, imem_req}, 32'h0);
    tick();
    lit("late_ack_valid", {31'b0, IF_valid}, 32'h0);
    setin(1'b1, 1'b0, 1'b0, 32'h0, 1'b1);
    lit("post_rst_addr", imem_addr, 32'h500);
    tick();
    lit("post_rst_pc", IF_pc, 32'h500);

    setin(1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
    tick();
    tick();
    chk_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
